// File: rtl/carry_pkg.sv
// Shared definitions for explicit-carry arithmetic blocks.
// Contents:
//    CARRY_CHUNK_DEFAULT  default number of bits per carry-chain slice
//    seg_ctl_t            per-segment control pair (valid, carry)
//    carry_cell()         one carry-chain bit: select s, fabric input di, carry in ci
//                         returns {co, o} with co = s ? ci : di, o = s ^ ci
package carry_pkg;

   localparam int CARRY_CHUNK_DEFAULT = 4;

   typedef struct packed {
      logic v;
      logic c;
   } seg_ctl_t;

   // One bit of a mux-based carry chain. With s = a ^ b and di = a the carry
   // either propagates (s=1) or is generated/killed by a (s=0).
   function automatic logic [1:0] carry_cell(input logic ci, input logic di, input logic s);
      return {(s ? ci : di), (s ^ ci)};
   endfunction

endpackage

// File: rtl/carry_chunk.sv
// Combinational CHUNK-bit adder segment built as a ripple of carry cells so it
// maps onto one hardware carry-chain slice.
// Ports:
//    ci        carry into bit 0
//    a, b      segment operands (b already inverted for subtraction)
//    sum       segment sum bits
//    co        carry out of the top bit
//    c_msb_in  carry into the top bit (used for signed overflow)
module carry_chunk
   import carry_pkg::*;
#(
   parameter int CHUNK = CARRY_CHUNK_DEFAULT
) (
   input  logic             ci,
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic [CHUNK-1:0] sum,
   output logic             co,
   output logic             c_msb_in
);

   logic [CHUNK:0] carry;

   // Ripple through the chain: carry[i] enters bit i, carry[CHUNK] leaves the slice.
   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = ci;
      for (int i = 0; i < CHUNK; i++) begin
         {carry[i+1], sum[i]} = carry_cell(carry[i], a[i], a[i] ^ b[i]);
      end
      co       = carry[CHUNK];
      c_msb_in = carry[CHUNK-1];
   end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Segmented, pipelined WIDTH-bit adder/subtractor. Each CHUNK-bit segment is
// summed by its own carry_chunk; the segment carry-out is registered and used
// by the next segment one cycle later. Operand bits not yet summed travel
// down the pipe as skew registers. The last stage is the output register.
// Ports:
//    clk, rst_n             clock, asynchronous active-low reset
//    in_valid/in_ready      input handshake; in_a, in_b, in_sub, in_cin sampled on accept
//    out_valid/out_ready    output handshake; out_sum, out_cout, out_ovf held while stalled
module pipelined_carry_adder
   import carry_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = CARRY_CHUNK_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int STAGES = WIDTH / CHUNK;

   if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_width
      $error("pipelined_carry_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   logic [WIDTH-1:0]  b_eff;
   logic              cin_eff;
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] adv;

   // Subtraction is A + ~B + 1, so inverting B and flipping the carry-in covers both.
   assign b_eff   = in_sub ? ~in_b : in_b;
   assign cin_eff = in_cin ^ in_sub;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK-1:0] seg_a;
      logic [CHUNK-1:0] seg_b;
      logic [CHUNK-1:0] seg_sum;
      logic             seg_ci;
      logic             seg_co;
      logic             seg_cmsb;
      logic             src_v;
      logic [WIDTH-1:0] src_sum;
      logic [WIDTH-1:0] sum_d;
      logic [WIDTH-1:0] sum_r;
      logic             v_r;
      logic             c_r;

      assign v_q[k] = v_r;

      // Unrolled form of adv[k] = !v[k] || adv[k+1]: a stage may move if the
      // output drains or any stage from here to the output holds a bubble.
      assign adv[k] = out_ready || !(&v_q[STAGES-1:k]);

      // Segment k's operands come straight from the input beat for stage 0,
      // otherwise from the low chunk of the previous stage's skew registers.
      if (k == 0) begin : g_src
         assign seg_a   = in_a[CHUNK-1:0];
         assign seg_b   = b_eff[CHUNK-1:0];
         assign seg_ci  = cin_eff;
         assign src_v   = in_valid;
         assign src_sum = '0;
      end else begin : g_src
         assign seg_a   = g_stage[k-1].g_skew.skew_a[CHUNK-1:0];
         assign seg_b   = g_stage[k-1].g_skew.skew_b[CHUNK-1:0];
         assign seg_ci  = g_stage[k-1].c_r;
         assign src_v   = g_stage[k-1].v_r;
         assign src_sum = g_stage[k-1].sum_r;
      end

      carry_chunk #(
         .CHUNK(CHUNK)
      ) u_chunk (
         .ci       (seg_ci),
         .a        (seg_a),
         .b        (seg_b),
         .sum      (seg_sum),
         .co       (seg_co),
         .c_msb_in (seg_cmsb)
      );

      always_comb begin
         sum_d                     = src_sum;
         sum_d[k*CHUNK +: CHUNK]   = seg_sum;
      end

      // Stage register: loads only when it may advance and a real beat arrives,
      // so a stalled output keeps its value and bubbles leave data untouched.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_r   <= 1'b0;
            c_r   <= 1'b0;
            sum_r <= '0;
         end else if (adv[k]) begin
            v_r <= src_v;
            if (src_v) begin
               c_r   <= seg_co;
               sum_r <= sum_d;
            end
         end
      end

      // Operand bits for segments k+1 .. STAGES-1, next segment in the low chunk.
      if (k < STAGES-1) begin : g_skew
         localparam int SW = (STAGES-1-k) * CHUNK;
         logic [SW-1:0] skew_a;
         logic [SW-1:0] skew_b;
         logic [SW-1:0] skew_a_d;
         logic [SW-1:0] skew_b_d;

         if (k == 0) begin : g_first
            assign skew_a_d = in_a[WIDTH-1:CHUNK];
            assign skew_b_d = b_eff[WIDTH-1:CHUNK];
         end else begin : g_next
            assign skew_a_d = g_stage[k-1].g_skew.skew_a[SW+CHUNK-1:CHUNK];
            assign skew_b_d = g_stage[k-1].g_skew.skew_b[SW+CHUNK-1:CHUNK];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               skew_a <= '0;
               skew_b <= '0;
            end else if (adv[k] && src_v) begin
               skew_a <= skew_a_d;
               skew_b <= skew_b_d;
            end
         end
      end

      // Only the top segment's carry-into-MSB matters: it feeds signed overflow.
      if (k == STAGES-1) begin : g_last
         logic ovf_r;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_r <= 1'b0;
            end else if (adv[k] && src_v) begin
               ovf_r <= seg_cmsb ^ seg_co;
            end
         end
      end else begin : g_mid
         logic cmsb_unused;
         assign cmsb_unused = seg_cmsb;
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v_q[STAGES-1];
   assign out_sum   = g_stage[STAGES-1].sum_r;
   assign out_cout  = g_stage[STAGES-1].c_r;
   assign out_ovf   = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder (WIDTH=32, CHUNK=4).
// A queue-based reference model computes every expected result with plain
// 33-bit arithmetic; directed cases also compare against literal values.
module tb_pipelined_carry_adder;

   localparam int WIDTH = 32;
   localparam int CHUNK = 4;
   localparam int STAGES = WIDTH / CHUNK;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } res_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   int   checks = 0;
   int   failures = 0;
   int   n_accepted = 0;
   int   n_drained = 0;
   res_t exp_q[$];
   res_t got;
   logic s_valid;
   logic s_in_ready;
   logic [WIDTH-1:0] s_sum;
   logic s_cout;
   logic s_ovf;

   pipelined_carry_adder #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-precision sum, carry is bit WIDTH, overflow from operand/result signs.
   function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sub, input logic cin);
      logic [WIDTH:0]   full;
      logic [WIDTH-1:0] bb;
      res_t             r;
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(cin ^ sub);
      r.sum  = full[WIDTH-1:0];
      r.cout = full[WIDTH];
      r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
      return r;
   endfunction

   task automatic check_output(input string tag, input logic [WIDTH-1:0] obs,
                               input logic [WIDTH-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // One clock: drive at the falling edge, sample 1ns later, let the rising edge act.
   task automatic apply_stimulus(input logic iv, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic sub,
                                 input logic cin, input logic ordy);
      res_t e;
      @(negedge clk);
      in_valid  = iv;
      in_a      = a;
      in_b      = b;
      in_sub    = sub;
      in_cin    = cin;
      out_ready = ordy;
      #1;
      s_valid    = out_valid;
      s_in_ready = in_ready;
      s_sum      = out_sum;
      s_cout     = out_cout;
      s_ovf      = out_ovf;
      if (out_valid && out_ready) begin
         n_drained++;
         got = '{sum: out_sum, cout: out_cout, ovf: out_ovf};
         if (exp_q.size() == 0) begin
            check_output("unexpected_beat", {31'd0, out_valid}, '0);
         end else begin
            e = exp_q.pop_front();
            check_output("sum", out_sum, e.sum);
            check_output("cout", {31'd0, out_cout}, {31'd0, e.cout});
            check_output("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
         end
      end
      if (in_valid && in_ready) begin
         n_accepted++;
         exp_q.push_back(model(a, b, sub, cin));
      end
   endtask

   task automatic idle(input logic ordy);
      apply_stimulus(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), ordy);
   endtask

   // Bounded drain: leftover entries after the budget count as a failure.
   task automatic drain_wait(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) idle(1'b1);
      check_output("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic sub, input logic cin, input logic [WIDTH-1:0] esum,
                           input logic ecout, input logic eovf);
      apply_stimulus(1'b1, a, b, sub, cin, 1'b1);
      drain_wait(20);
      check_output({tag, "_sum"}, got.sum, esum);
      check_output({tag, "_cout"}, {31'd0, got.cout}, {31'd0, ecout});
      check_output({tag, "_ovf"}, {31'd0, got.ovf}, {31'd0, eovf});
   endtask

   initial begin
      int base;
      int unstable;
      logic [WIDTH-1:0] hold_sum;
      logic hold_cout;
      logic hold_ovf;
      logic hold_seen;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      in_cin    = 1'b0;
      out_ready = 1'b0;
      got       = '0;

      // Reset state
      #2;
      check_output("rst_out_valid", {31'd0, out_valid}, '0);
      check_output("rst_out_sum", out_sum, '0);
      check_output("rst_out_cout", {31'd0, out_cout}, '0);
      check_output("rst_out_ovf", {31'd0, out_ovf}, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Latency: accepted beat appears exactly STAGES cycles later
      $display("[TB] latency and directed cases");
      apply_stimulus(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
      repeat (STAGES - 1) idle(1'b1);
      check_output("lat_early", {31'd0, s_valid}, '0);
      idle(1'b1);
      check_output("lat_exact", {31'd0, s_valid}, 32'd1);
      check_output("add_sum", got.sum, 32'h0000_0003);
      check_output("add_cout", {31'd0, got.cout}, '0);
      check_output("add_ovf", {31'd0, got.ovf}, '0);

      directed("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      directed("sub_borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);

      // Back-to-back random beats: one result per cycle, in_ready never drops
      $display("[TB] back-to-back random beats");
      base = n_drained;
      unstable = 0;
      for (int i = 0; i < 100; i++) begin
         apply_stimulus(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
         if (!s_in_ready) unstable++;
      end
      check_output("b2b_in_ready_drops", 32'(unstable), '0);
      check_output("b2b_drained_during", 32'(n_drained - base), 32'(100 - STAGES));
      repeat (STAGES) idle(1'b1);
      check_output("b2b_drained_total", 32'(n_drained - base), 32'd100);
      check_output("b2b_queue_empty", 32'(exp_q.size()), '0);

      // Backpressure: full pipe holds exactly STAGES beats, output stays stable
      $display("[TB] backpressure");
      base      = n_accepted;
      unstable  = 0;
      hold_seen = 1'b0;
      hold_sum  = '0;
      hold_cout = 1'b0;
      hold_ovf  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
         if (s_valid) begin
            if (!hold_seen) begin
               hold_seen = 1'b1;
               hold_sum  = s_sum;
               hold_cout = s_cout;
               hold_ovf  = s_ovf;
            end else if (s_sum !== hold_sum || s_cout !== hold_cout || s_ovf !== hold_ovf) begin
               unstable++;
            end
         end
      end
      check_output("bp_accepted", 32'(n_accepted - base), 32'(STAGES));
      check_output("bp_in_ready", {31'd0, s_in_ready}, '0);
      check_output("bp_out_valid", {31'd0, s_valid}, 32'd1);
      check_output("bp_unstable", 32'(unstable), '0);
      check_output("bp_held_sum", hold_sum, exp_q[0].sum);
      base = n_drained;
      drain_wait(20);
      check_output("bp_drained", 32'(n_drained - base), 32'(STAGES));

      // Reset with beats in flight: outputs clear at once, nothing stale emerges
      $display("[TB] reset mid-operation");
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, $urandom | 32'h0000_0100, $urandom, 1'b0, 1'b0, 1'b0);
      end
      repeat (4) idle(1'b0);
      check_output("inflight_out_valid", {31'd0, s_valid}, 32'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("arst_out_valid", {31'd0, out_valid}, '0);
      check_output("arst_out_sum", out_sum, '0);
      check_output("arst_in_ready", {31'd0, in_ready}, 32'd1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      base = n_drained;
      repeat (20) idle(1'b1);
      check_output("post_rst_no_stale", 32'(n_drained - base), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute watchdog so the run always terminates.
   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
